teclado_grid_cursor: RTL and testbench



---
 rtl/teclado_grid_cursor_pkg.sv | 14 +
 rtl/teclado_grid_cursor_if.sv | 20 ++
 rtl/teclado_grid_cursor_blink_timer.sv | 28 ++
 rtl/teclado_grid_cursor.sv | 77 +++++++
 tb/tb_teclado_grid_cursor.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/teclado_grid_cursor_pkg.sv
// teclado_pkg: default keypad geometry and the key index map shared with the key decoder
package teclado_pkg;
  localparam int COLS_DEF = 5;
  localparam int ROWS_DEF = 5;
  localparam int X0_DEF = 0;
  localparam int Y0_DEF = 0;
  localparam int K_7 = 0, K_8 = 1, K_9 = 2, K_DIV = 3, K_AC = 4;
  localparam int K_4 = 5, K_5 = 6, K_6 = 7, K_MUL = 8, K_BORRAR = 9;
  localparam int K_1 = 10, K_2 = 11, K_3 = 12, K_RES = 13, K_CE = 14;
  localparam int K_0 = 15, K_PUNTO = 16, K_RAIZ = 17, K_SUM = 18, K_IGUAL = 19;
  localparam int K_A = 20, K_B = 21, K_C = 22, K_D = 23, K_E = 24;
  // K_F is only reachable on builds with at least 26 keys
  localparam int K_F = 25;
endpackage

// File: rtl/teclado_grid_cursor_if.sv
// teclado_grid_cursor_if: cell coordinates, button pulses and key outputs of the keypad overlay
interface teclado_grid_cursor_if #(
  parameter int XW = 5,
  parameter int YW = 4,
  parameter int PW = 5
);
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
  logic frame_tick, btn_up, btn_down, btn_left, btn_right, btn_ok;
  logic borde, hl, key_valid;
  logic [PW-1:0] pos, key_code;
  modport master (
    output X, Y, frame_tick, btn_up, btn_down, btn_left, btn_right, btn_ok,
    input borde, hl, pos, key_valid, key_code
  );
  modport slave (
    input X, Y, frame_tick, btn_up, btn_down, btn_left, btn_right, btn_ok,
    output borde, hl, pos, key_valid, key_code
  );
endinterface

// File: rtl/teclado_grid_cursor_blink_timer.sv
// blink_timer: blink phase toggled every BLINK_FRAMES frames; restart forces the visible phase
module blink_timer #(
  parameter int BLINK_FRAMES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  input  logic restart,
  output logic phase
);
  localparam int CW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic phase_q, phase_d;
  always_comb begin
    cnt_d = restart ? '0 : frame_tick ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
    phase_d = restart ? 1'b1 : (frame_tick && cnt_q == LAST) ? ~phase_q : phase_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
    end
  assign phase = phase_q;
endmodule

// File: rtl/teclado_grid_cursor.sv
// teclado_grid_cursor: keypad grid overlay with a wrap-around blinking cursor and key confirm
module teclado_grid_cursor
  import teclado_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int XW = 5,
  parameter int YW = 4,
  parameter int X0 = X0_DEF,
  parameter int Y0 = Y0_DEF,
  parameter int BLINK_FRAMES = 16,
  parameter int PW = $clog2(COLS * ROWS)
) (
  input logic clk,
  input logic rst_n,
  teclado_grid_cursor_if.slave bus
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
  localparam logic [XW:0] X_LO = (XW+1)'(X0);
  localparam logic [XW:0] X_HI = (XW+1)'(X0 + 2 * COLS);
  localparam logic [YW:0] Y_LO = (YW+1)'(Y0);
  localparam logic [YW:0] Y_HI = (YW+1)'(Y0 + 2 * ROWS);
  localparam logic [PW-1:0] COLS_P = PW'(COLS);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [PW-1:0] key_code_q, key_code_d;
  logic key_valid_q, borde_q, borde_d, hl_q, hl_d, moved, phase, in_box;
  logic [XW:0] dx;
  logic [YW:0] dy;
  always_comb begin
    row_d = bus.btn_up ? (row_q == '0 ? R_LAST : row_q - 1'b1) :
            bus.btn_down ? (row_q == R_LAST ? '0 : row_q + 1'b1) : row_q;
    col_d = (bus.btn_up | bus.btn_down) ? col_q :
            bus.btn_left ? (col_q == '0 ? C_LAST : col_q - 1'b1) :
            bus.btn_right ? (col_q == C_LAST ? '0 : col_q + 1'b1) : col_q;
    moved = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
    key_code_d = bus.btn_ok ? bus.pos : key_code_q;
    // offsets from the grid origin; one extra bit keeps cells left/above the box from aliasing
    dx = {1'b0, bus.X} - X_LO;
    dy = {1'b0, bus.Y} - Y_LO;
    in_box = {1'b0, bus.X} >= X_LO && {1'b0, bus.X} <= X_HI &&
             {1'b0, bus.Y} >= Y_LO && {1'b0, bus.Y} <= Y_HI;
    borde_d = in_box & (~dx[0] | ~dy[0]);
    hl_d = phase & in_box & (dx == (XW+1)'({col_q, 1'b1})) & (dy == (YW+1)'({row_q, 1'b1}));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      key_code_q <= '0;
      key_valid_q <= 1'b0;
      borde_q <= 1'b0;
      hl_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      key_code_q <= key_code_d;
      key_valid_q <= bus.btn_ok;
      borde_q <= borde_d;
      hl_q <= hl_d;
    end
  blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(bus.frame_tick),
    .restart(moved),
    .phase(phase)
  );
  assign bus.pos = PW'(row_q) * COLS_P + PW'(col_q);
  assign bus.key_code = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.borde = borde_q;
  assign bus.hl = hl_q;
endmodule

// File: tb/tb_teclado_grid_cursor.sv
// tb_teclado_grid_cursor: vector table for the cursor, scoreboard for geometry and blink
module tb_teclado_grid_cursor;
  import teclado_pkg::*;
  typedef struct { logic u, d, l, r, ok; int pos, kv, kc; } vec_t;
  typedef struct { logic ft, r; int x, y, hl; } bl_t;
  typedef struct { int x, y, borde, hl; } gv_t;
  typedef struct { string nm; int borde, hl; } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int checks = 0, errors = 0;
  exp_t sb[$];
  vec_t vecs[17];
  bl_t bls[11];
  gv_t gvs[8];
  always #5 clk = ~clk;
  teclado_grid_cursor_if #(.XW(5), .YW(4), .PW(5)) a_if ();
  teclado_grid_cursor_if #(.XW(5), .YW(4), .PW(5)) b_if ();
  teclado_grid_cursor #(.COLS(COLS_DEF), .ROWS(ROWS_DEF), .XW(5), .YW(4), .X0(X0_DEF),
    .Y0(Y0_DEF), .BLINK_FRAMES(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  teclado_grid_cursor #(.COLS(4), .ROWS(7), .XW(5), .YW(4), .X0(3), .Y0(1),
    .BLINK_FRAMES(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic btn_a(input logic u, d, l, r, ok);
    a_if.btn_up = u;
    a_if.btn_down = d;
    a_if.btn_left = l;
    a_if.btn_right = r;
    a_if.btn_ok = ok;
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " borde"}, int'(a_if.borde), 0);
    chk({nm, " hl"}, int'(a_if.hl), 0);
    chk({nm, " pos"}, int'(a_if.pos), 0);
    chk({nm, " key_valid"}, int'(a_if.key_valid), 0);
    chk({nm, " key_code"}, int'(a_if.key_code), 0);
  endtask
  task automatic sb_check(input int b, input int h);
    exp_t e;
    if (sb.size() == 0) chk("scoreboard underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk({e.nm, " borde"}, b, e.borde);
      chk({e.nm, " hl"}, h, e.hl);
    end
  endtask
  initial begin
    int nb, mb, nh, eb, eh;
    a_if.X = '0; a_if.Y = '0; a_if.frame_tick = 1'b0;
    b_if.X = '0; b_if.Y = '0; b_if.frame_tick = 1'b0;
    btn_a(0, 0, 0, 0, 0);
    b_if.btn_up = 1'b0; b_if.btn_down = 1'b0; b_if.btn_left = 1'b0;
    b_if.btn_right = 1'b0; b_if.btn_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("power-on reset");
    chk("B reset pos", int'(b_if.pos), 0);
    #2 rst_n = 1'b1;
    tick();
    btn_a(0, 0, 0, 1, 0);
    tick();
    chk("pre-reset move pos", int'(a_if.pos), 1);
    a_if.X = 5'd2; a_if.Y = 4'd0;
    btn_a(0, 0, 0, 0, 1);
    tick();
    btn_a(0, 0, 0, 0, 0);
    chk("pre-reset key_valid", int'(a_if.key_valid), 1);
    chk("pre-reset key_code", int'(a_if.key_code), 1);
    chk("pre-reset borde", int'(a_if.borde), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset");
    for (int i = 0; i < 3; i++) begin
      a_if.X = 5'($urandom_range(0, 31));
      a_if.Y = 4'($urandom_range(0, 15));
      a_if.frame_tick = 1'($urandom_range(0, 1));
      btn_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      chk_reset("held reset");
    end
    a_if.frame_tick = 1'b0;
    btn_a(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    nb = 0; mb = 0; nh = 0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 32; x++) begin
        a_if.X = 5'(x);
        a_if.Y = 4'(y);
        eb = (x <= 10 && y <= 10 && (x % 2 == 0 || y % 2 == 0)) ? 1 : 0;
        eh = (x == 1 && y == 1) ? 1 : 0;
        mb += eb;
        sb.push_back('{$sformatf("sweep x=%0d y=%0d", x, y), eb, eh});
        tick();
        nb += int'(a_if.borde);
        nh += int'(a_if.hl);
        sb_check(int'(a_if.borde), int'(a_if.hl));
      end
    chk("borde count", nb, mb);
    chk("hl count", nh, 1);
    a_if.X = 5'd11; a_if.Y = 4'd3;
    tick();
    chk("outside x=11 y=3 borde", int'(a_if.borde), 0);
    vecs[0] = '{0, 0, 1, 0, 0, 4, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 0, 24, 0, 0};
    vecs[2] = '{0, 0, 0, 1, 0, 20, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 1, 20, 1, 20};
    vecs[4] = '{0, 0, 0, 0, 0, 20, 0, 20};
    vecs[5] = '{0, 1, 0, 0, 0, 0, 0, 20};
    vecs[6] = '{1, 1, 0, 0, 0, 20, 0, 20};
    vecs[7] = '{0, 1, 1, 1, 0, 0, 0, 20};
    vecs[8] = '{0, 0, 1, 1, 0, 4, 0, 20};
    vecs[9] = '{0, 0, 0, 1, 0, 0, 0, 20};
    vecs[10] = '{0, 1, 0, 0, 0, 5, 0, 20};
    vecs[11] = '{0, 0, 0, 1, 0, 6, 0, 20};
    vecs[12] = '{0, 0, 0, 1, 0, 7, 0, 20};
    vecs[13] = '{1, 0, 0, 1, 1, 2, 1, 7};
    vecs[14] = '{0, 0, 0, 0, 1, 2, 1, 2};
    vecs[15] = '{0, 1, 0, 0, 1, 7, 1, 2};
    vecs[16] = '{0, 0, 0, 0, 0, 7, 0, 2};
    for (int i = 0; i < 17; i++) begin
      btn_a(vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].ok);
      tick();
      chk($sformatf("vec %0d pos", i), int'(a_if.pos), vecs[i].pos);
      chk($sformatf("vec %0d key_valid", i), int'(a_if.key_valid), vecs[i].kv);
      chk($sformatf("vec %0d key_code", i), int'(a_if.key_code), vecs[i].kc);
    end
    btn_a(0, 0, 0, 0, 0);
    bls[0] = '{1, 0, 5, 3, 1};
    bls[1] = '{1, 0, 5, 3, 1};
    bls[2] = '{0, 0, 5, 3, 0};
    bls[3] = '{1, 0, 5, 3, 0};
    bls[4] = '{1, 0, 5, 3, 0};
    bls[5] = '{1, 0, 5, 3, 1};
    bls[6] = '{1, 1, 5, 3, 1};
    bls[7] = '{0, 0, 7, 3, 1};
    bls[8] = '{1, 0, 7, 3, 1};
    bls[9] = '{1, 0, 7, 3, 1};
    bls[10] = '{0, 0, 7, 3, 0};
    for (int i = 0; i < 11; i++) begin
      a_if.frame_tick = bls[i].ft;
      a_if.btn_right = bls[i].r;
      a_if.X = 5'(bls[i].x);
      a_if.Y = 4'(bls[i].y);
      sb.push_back('{$sformatf("blink step %0d", i), 0, bls[i].hl});
      tick();
      sb_check(int'(a_if.borde), int'(a_if.hl));
    end
    a_if.frame_tick = 1'b0;
    a_if.btn_right = 1'b0;
    chk("blink move pos", int'(a_if.pos), 8);
    gvs[0] = '{3, 1, 1, 0};
    gvs[1] = '{4, 2, 0, 1};
    gvs[2] = '{2, 1, 0, 0};
    gvs[3] = '{11, 15, 1, 0};
    gvs[4] = '{12, 15, 0, 0};
    gvs[5] = '{5, 3, 1, 0};
    gvs[6] = '{4, 3, 1, 0};
    gvs[7] = '{6, 2, 0, 0};
    for (int i = 0; i < 8; i++) begin
      b_if.X = 5'(gvs[i].x);
      b_if.Y = 4'(gvs[i].y);
      sb.push_back('{$sformatf("B geom x=%0d y=%0d", gvs[i].x, gvs[i].y), gvs[i].borde, gvs[i].hl});
      tick();
      sb_check(int'(b_if.borde), int'(b_if.hl));
    end
    b_if.btn_down = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("B down %0d pos", i), int'(b_if.pos), (i % 7) * 4);
    end
    b_if.btn_down = 1'b0;
    tick();
    chk("B idle pos", int'(b_if.pos), 0);
    chk("scoreboard drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
